// File: rtl/rx_inpi1556fch.sv
// Single-wire LED protocol receiver.
// Samples din through a 2-flop synchroniser and classifies each high pulse by width.
// Bits are assembled MSB-first into 24-bit colour words.
// Detects the inter-frame reset gap on the line.
// Optional feature macro: RX_FORWARD_EN enables daisy-chain forwarding on dout.
// Without it, dout is tied 0.
module rx_inpi1556fch #(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned MIN_HIGH   = 10,
  parameter int unsigned THRESH     = 45,
  parameter int unsigned MAX_HIGH   = 100,
  parameter int unsigned RESET_CLKS = 8000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] color,
  output logic        valid,
  output logic        frame_end,
  output logic        err,
  output logic        busy,
  output logic        dout
);

  typedef enum logic [1:0] {StSync, StIdle, StHigh, StLow} state_e;

  localparam logic [CNT_W-1:0] MinHighC   = CNT_W'(MIN_HIGH);
  localparam logic [CNT_W-1:0] ThreshC    = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] MaxHighC   = CNT_W'(MAX_HIGH);
  localparam logic [CNT_W-1:0] ResetLastC = CNT_W'(RESET_CLKS - 1);

  state_e             state_q, state_d;
  logic               din_meta_q, din_s_q, din_d1_q;
  logic [CNT_W-1:0]   hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]   lo_cnt_q, lo_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [23:0]        sr_q, sr_d;
  logic [23:0]        color_q, color_d;
  logic               valid_q, valid_d;
  logic               frame_end_q, frame_end_d;
  logic               err_q, err_d;

  logic rise, pulse_bad, pulse_bit, gap, word_done;

  assign rise      = din_s_q & ~din_d1_q;
  assign pulse_bad = (hi_cnt_q < MinHighC) || (hi_cnt_q > MaxHighC);
  assign pulse_bit = (hi_cnt_q >= ThreshC);
  // lo_cnt_q counts earlier low clocks, so this is the RESET_CLKS-th consecutive low.
  assign gap       = ~din_s_q && (lo_cnt_q == ResetLastC);
  assign word_done = (bit_cnt_q == 5'd24);

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StSync;
      din_meta_q  <= 1'b0;
      din_s_q     <= 1'b0;
      din_d1_q    <= 1'b0;
      hi_cnt_q    <= '0;
      lo_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      color_q     <= '0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      din_meta_q  <= din;
      din_s_q     <= din_meta_q;
      din_d1_q    <= din_s_q;
      hi_cnt_q    <= hi_cnt_d;
      lo_cnt_q    <= lo_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      sr_q        <= sr_d;
      color_q     <= color_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      err_q       <= err_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSync: if (gap) state_d = StIdle;
      StIdle: if (rise) state_d = StHigh;
      StHigh: if (!din_s_q) state_d = pulse_bad ? StSync : StLow;
      // In StLow a high on din_s can only be a rising edge.
      StLow: begin
        if (din_s_q) state_d = StHigh;
        else if (gap) state_d = StIdle;
      end
      default: state_d = StSync;
    endcase
  end

  // Counters, shift register and pulse outputs.
  always_comb begin
    hi_cnt_d    = hi_cnt_q;
    lo_cnt_d    = lo_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    sr_d        = sr_q;
    color_d     = color_q;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;

    // Publish the word one clock after its 24th bit; no classify can land on this clock.
    if (word_done) begin
      color_d   = sr_q;
      valid_d   = 1'b1;
      bit_cnt_d = '0;
    end

    unique case (state_q)
      StSync: begin
        if (din_s_q || gap) lo_cnt_d = '0;
        else                lo_cnt_d = lo_cnt_q + CNT_W'(1);
      end
      StIdle: begin
        // The rising-edge clock is the first high clock of the pulse.
        if (rise) begin
          hi_cnt_d = CNT_W'(1);
          lo_cnt_d = '0;
        end
      end
      StHigh: begin
        if (din_s_q) begin
          if (hi_cnt_q != '1) hi_cnt_d = hi_cnt_q + CNT_W'(1);
        end else if (pulse_bad) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          sr_d      = '0;
          lo_cnt_d  = CNT_W'(1);
        end else begin
          sr_d      = {sr_q[22:0], pulse_bit};
          bit_cnt_d = bit_cnt_q + 5'd1;
          // The falling-edge clock is the first low clock.
          lo_cnt_d  = CNT_W'(1);
        end
      end
      StLow: begin
        if (din_s_q) begin
          hi_cnt_d = CNT_W'(1);
          lo_cnt_d = '0;
        end else if (gap) begin
          frame_end_d = 1'b1;
          err_d       = (bit_cnt_q != '0);
          bit_cnt_d   = '0;
          sr_d        = '0;
          lo_cnt_d    = '0;
        end else begin
          lo_cnt_d = lo_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

`ifdef RX_FORWARD_EN
  logic fwd_q, fwd_d;
  logic dout_q, dout_d;

  // Forwarding opens after the first word of a frame and closes at the gap or on an error.
  always_comb begin
    fwd_d = fwd_q;
    if (valid_d) fwd_d = 1'b1;
    if (frame_end_d || err_d) fwd_d = 1'b0;
    dout_d = fwd_q & din_d1_q;
  end

  // Forwarding gate and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_q  <= 1'b0;
      dout_q <= 1'b0;
    end else begin
      fwd_q  <= fwd_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

  assign color     = color_q;
  assign valid     = valid_q;
  assign frame_end = frame_end_q;
  assign err       = err_q;
  assign busy      = (bit_cnt_q != '0);

endmodule

// File: tb/tb_rx_inpi1556fch.sv
// Scoreboard bench for rx_inpi1556fch: expected pulse events are queued as stimulus is issued,
// and a monitor pops and compares them whenever valid, err or frame_end is seen.
module tb_rx_inpi1556fch;

  typedef struct packed {
    logic        v;
    logic        e;
    logic        f;
    logic [23:0] c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        din;
  logic [23:0] color;
  logic        valid, frame_end, err, busy, dout;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dout_ones = 0;
  int   fwd_mode = 0;
  int   fwd_bad = 0;
  int   fwd_ones = 0;
  logic [7:0] din_hist = '0;
  logic [23:0] cur_color = '0;

  rx_inpi1556fch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .color     (color),
    .valid     (valid),
    .frame_end (frame_end),
    .err       (err),
    .busy      (busy),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Hold din at v for exactly n rising edges.
  task automatic drive(input logic v, input int n);
    din = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [23:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      if (w[i]) begin
        drive(1'b1, 60);
        drive(1'b0, 60);
      end else begin
        drive(1'b1, 30);
        drive(1'b0, 90);
      end
    end
  endtask

  task automatic push(input logic v, input logic e, input logic f);
    ev_t ev;
    ev.v = v;
    ev.e = e;
    ev.f = f;
    ev.c = cur_color;
    exp_q.push_back(ev);
  endtask

  task automatic expect_word(input logic [23:0] w);
    cur_color = w;
    push(1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_color"}, {8'h0, color}, 32'h0);
    chk({tag, "_pulses"}, {29'h0, valid, err, frame_end}, 32'h0);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_dout"}, {31'h0, dout}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    din   = 1'b0;

    // Monitor: compares each output event against the queue head; also watches dout.
    fork
      forever begin
        ev_t got;
        ev_t want;
        @(negedge clk);
        din_hist = {din_hist[6:0], din};
        if (dout) dout_ones++;
        if (fwd_mode == 1 && dout) fwd_bad++;
        if (fwd_mode == 2) begin
          if (dout !== din_hist[4]) fwd_bad++;
          if (dout) fwd_ones++;
        end
        if (rst_n && (valid || err || frame_end)) begin
          got = '{v: valid, e: err, f: frame_end, c: color};
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got v=%b e=%b f=%b color=%h, expected none",
                     valid, err, frame_end, color);
          end else begin
            want = exp_q.pop_front();
            chk("event", {5'h0, got}, {5'h0, want});
          end
        end
      end
    join_none

    #20;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 8100);

    // 1: single word.
    expect_word(24'h0FF0A5);
    send_bits(24'h0FF0A5, 23, 0);
    chk("t1_color", {8'h0, color}, 32'h000FF0A5);

    // 2: word then gap; busy mid-word and after valid.
    expect_word(24'h123456);
    send_bits(24'h123456, 23, 19);
    chk("t2_busy_mid", {31'h0, busy}, 32'h1);
    send_bits(24'h123456, 18, 0);
    chk("t2_busy_after", {31'h0, busy}, 32'h0);
    push(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8100);

    // 3: glitch after 10 bits, resync, then a clean word.
    push(1'b0, 1'b1, 1'b0);
    send_bits(24'h2AB000, 23, 14);
    drive(1'b1, 5);
    drive(1'b0, 8100);
    chk("t3_busy", {31'h0, busy}, 32'h0);
    expect_word(24'hABCDEF);
    send_bits(24'hABCDEF, 23, 0);
    push(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8100);

    // 4: partial word at gap -> err and frame_end together, color held.
    push(1'b0, 1'b1, 1'b1);
    send_bits(24'h555000, 23, 14);
    drive(1'b0, 8100);
    chk("t4_color", {8'h0, color}, 32'h00ABCDEF);

    // 5: boundary widths 44/45/10/100 -> 0/1/0/1, then 9, 101 and a long high -> err.
    expect_word(24'h5ABCDE);
    drive(1'b1, 44);
    drive(1'b0, 60);
    drive(1'b1, 45);
    drive(1'b0, 60);
    drive(1'b1, 10);
    drive(1'b0, 60);
    drive(1'b1, 100);
    drive(1'b0, 60);
    send_bits(24'h0ABCDE, 19, 0);
    push(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8100);
    push(1'b0, 1'b1, 1'b0);
    drive(1'b1, 9);
    drive(1'b0, 8100);
    push(1'b0, 1'b1, 1'b0);
    drive(1'b1, 101);
    drive(1'b0, 8100);
    push(1'b0, 1'b1, 1'b0);
    drive(1'b1, 500);
    drive(1'b0, 8100);

    // 6: reset during bit 12's high phase, then a full word.
    send_bits(24'h3C5A96, 23, 12);
    din = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    cur_color = '0;
    din = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 8100);
    expect_word(24'h3C5A96);
    send_bits(24'h3C5A96, 23, 0);
    push(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8100);

`ifdef RX_FORWARD_EN
    // Forwarding: silent during word 1, follows din 4 clocks late during word 2.
    expect_word(24'h111111);
    fwd_mode = 1;
    send_bits(24'h111111, 23, 0);
    expect_word(24'h222222);
    fwd_mode = 2;
    send_bits(24'h222222, 23, 0);
    drive(1'b0, 20);
    fwd_mode = 0;
    push(1'b0, 1'b0, 1'b1);
    drive(1'b0, 8100);
    chk("fwd_mismatch_cycles", fwd_bad, 0);
    chk("fwd_high_cycles", fwd_ones, 6 * 60 + 18 * 30);
`else
    chk("dout_tied_low", dout_ones, 0);
`endif

    drive(1'b0, 20);
    chk("events_outstanding", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
